// File: rtl/shifter_arbiter.sv
// Round-robin scheduler that shares one shifter among NUM_REQ requesters.
// It picks a pending requester, captures its long vector, starts the shifter,
// waits for done (or for the watchdog limit) and reports back to the owner.
//
// Handshake: req[i] is a level that the requester holds until it sees grant[i].
// grant[i] is a one-cycle pulse in the same cycle as shifter_start. Once granted,
// the job runs to completion even if req[i] drops, and the owner is told the
// outcome by a one-cycle pulse on req_done[i] (ok) or req_error[i] (timeout).
// shifter_done is honoured only in RUN and ignored in every other state.
module shifter_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_WIDTH       = 2,
    parameter int IN_WIDTH       = 128,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*IN_WIDTH-1:0]  req_vector,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           req_done,
    output logic [NUM_REQ-1:0]           req_error,
    output logic                         shifter_start,
    output logic [IN_WIDTH-1:0]          shifter_vector,
    input  logic                         shifter_done,
    output logic [ID_WIDTH-1:0]          active_id,
    output logic                         busy,
    output logic [1:0]                   dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_RUN    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [IN_WIDTH-1:0]   vec_q, vec_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic [NUM_REQ-1:0]    err_q, err_d;
    logic                  start_q, start_d;
    logic                  busy_q, busy_d;

    logic                  found_hi, found_lo, req_any;
    int                    hi_idx, lo_idx, sel_idx;
    logic [IN_WIDTH-1:0]   sel_vec;

    function automatic logic [NUM_REQ-1:0] onehot(input int idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            v[j] = (j == idx);
        end
        return v;
    endfunction

    // Round-robin pick: first request at or above the pointer, else the first below it.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = 0;
        lo_idx   = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req[j] && !found_hi && (j >= int'(ptr_q))) begin
                found_hi = 1'b1;
                hi_idx   = j;
            end
            if (req[j] && !found_lo && (j < int'(ptr_q))) begin
                found_lo = 1'b1;
                lo_idx   = j;
            end
        end
        req_any = found_hi | found_lo;
        sel_idx = found_hi ? hi_idx : lo_idx;
    end

    // Mux out the slice of the selected requester.
    always_comb begin
        sel_vec = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (j == sel_idx) begin
                sel_vec = req_vector[j*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    // Next-state and next-output logic; all outputs are registered from these.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        grant_d = '0;
        done_d  = '0;
        err_d   = '0;
        start_d = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    state_d = S_START;
                    id_d    = ID_WIDTH'(sel_idx);
                    vec_d   = sel_vec;
                    grant_d = onehot(sel_idx);
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
            S_RUN: begin
                // Done beats the watchdog when both land on the same edge.
                if (shifter_done) begin
                    state_d = S_FINISH;
                    done_d  = onehot(int'(id_q));
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT)) begin
                    state_d = S_FINISH;
                    err_d   = onehot(int'(id_q));
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (int'(id_q) >= NUM_REQ - 1) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = id_q + ID_WIDTH'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight job silently.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

    assign grant          = grant_q;
    assign req_done       = done_q;
    assign req_error      = err_q;
    assign shifter_start  = start_q;
    assign shifter_vector = vec_q;
    assign active_id      = id_q;
    assign busy           = busy_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Bench for shifter_arbiter: random jobs against a transaction-level model of
// the round-robin scheduler and its watchdog, with a decoupled output monitor.
module tb_shifter_arbiter;

    localparam int N     = 4;
    localparam int IDW   = 2;
    localparam int W     = 128;
    localparam int T     = 50;
    localparam int NEVER = 1000;

    localparam int K_GRANT = 0;
    localparam int K_DONE  = 1;
    localparam int K_ERR   = 2;

    // ---------------- clock / reset ----------------
    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_vector;
    logic [N-1:0]   grant, req_done, req_error;
    logic           shifter_start;
    logic [W-1:0]   shifter_vector;
    logic           shifter_done;
    logic [IDW-1:0] active_id;
    logic           busy;
    logic [1:0]     dbg_state;

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    shifter_arbiter #(
        .NUM_REQ(N), .ID_WIDTH(IDW), .IN_WIDTH(W), .TIMEOUT_CYCLES(T)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .req_vector(req_vector),
        .grant(grant), .req_done(req_done), .req_error(req_error),
        .shifter_start(shifter_start), .shifter_vector(shifter_vector),
        .shifter_done(shifter_done), .active_id(active_id), .busy(busy),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int           kind;
        int           id;
        logic [W-1:0] vec;
        int           at;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   ptr_m  = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arbitration: scan requesters starting at the model pointer.
    function automatic int pick(input logic [N-1:0] pat);
        for (int i = 0; i < N; i++) begin
            if (pat[(ptr_m + i) % N]) return (ptr_m + i) % N;
        end
        return -1;
    endfunction

    // Monitor: whenever the DUT pulses an event, pop and compare.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && ((grant | req_done | req_error) != '0)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_event: grant=%b done=%b err=%b, none expected (cycle %0d)",
                             grant, req_done, req_error, cyc);
                end else begin
                    exp_t e;
                    logic [N-1:0] oh;
                    e  = exp_q.pop_front();
                    oh = N'(1) << e.id;
                    check("event_cycle", W'(cyc), W'(e.at));
                    check("grant", W'(grant), (e.kind == K_GRANT) ? W'(oh) : '0);
                    check("shifter_start", W'(shifter_start), W'(e.kind == K_GRANT));
                    check("req_done", W'(req_done), (e.kind == K_DONE) ? W'(oh) : '0);
                    check("req_error", W'(req_error), (e.kind == K_ERR) ? W'(oh) : '0);
                    check("active_id", W'(active_id), W'(e.id));
                    check("shifter_vector", shifter_vector, e.vec);
                    check("busy_in_job", W'(busy), W'(1));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic randomize_vectors();
        for (int j = 0; j < N; j++) begin
            req_vector[j*W +: W] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // One job: optional idle gap (with an optional stray done), then a request
    // pattern, then a shifter that answers after d RUN cycles (or never).
    // Returns at the negedge of the IDLE cycle that follows FINISH.
    task automatic run_job(input logic [N-1:0] pat, input int d, input int gap,
                           input bit stray, input bit hold);
        int id, g, span, kind;
        logic [W-1:0] vec;
        for (int i = 0; i < gap; i++) begin
            req          = '0;
            shifter_done = stray && (i == 0);
            @(negedge clock);
        end
        shifter_done = 1'b0;
        check("idle_busy", W'(busy), '0);
        randomize_vectors();
        req  = pat;
        id   = pick(pat);
        vec  = req_vector[id*W +: W];
        g    = cyc + 1;
        span = (d <= T) ? d + 1 : T + 1;
        kind = (d <= T) ? K_DONE : K_ERR;
        exp_q.push_back('{K_GRANT, id, vec, g});
        exp_q.push_back('{kind, id, vec, g + span});
        ptr_m = (id + 1) % N;
        @(negedge clock);
        if (!hold) req = N'($urandom_range(0, 15));
        randomize_vectors();
        for (int k = 1; k <= span; k++) begin
            @(negedge clock);
            shifter_done = (k == d);
        end
        @(negedge clock);
        shifter_done = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, W'(grant), '0);
        check({tag, "_req_done"}, W'(req_done), '0);
        check({tag, "_req_error"}, W'(req_error), '0);
        check({tag, "_shifter_start"}, W'(shifter_start), '0);
        check({tag, "_shifter_vector"}, shifter_vector, '0);
        check({tag, "_active_id"}, W'(active_id), '0);
        check({tag, "_busy"}, W'(busy), '0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [N-1:0] pat;
        int id;
        reset        = 1'b1;
        req          = '0;
        req_vector   = '0;
        shifter_done = 1'b0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        // Single request on requester 2.
        run_job(4'b0100, 20, 0, 1'b0, 1'b0);

        // All requesters held: strict rotation, one IDLE cycle between jobs.
        for (int i = 0; i < 5; i++) begin
            run_job(4'b1111, $urandom_range(1, 10), 0, 1'b0, 1'b1);
        end

        // Watchdog: never done, done on the limit edge, done one edge late.
        run_job(N'($urandom_range(1, 15)), NEVER, 1, 1'b0, 1'b0);
        run_job(N'($urandom_range(1, 15)), T, 0, 1'b0, 1'b0);
        run_job(N'($urandom_range(1, 15)), T + 1, 0, 1'b0, 1'b0);

        // Stray done while idle must be ignored.
        run_job(4'b1001, 5, 3, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 25; i++) begin
            run_job(N'($urandom_range(1, 15)), $urandom_range(1, T + 8),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset in the middle of RUN: job is dropped, pointer returns to 0.
        randomize_vectors();
        pat = 4'b0100;
        req = pat;
        id  = pick(pat);
        exp_q.push_back('{K_GRANT, id, req_vector[id*W +: W], cyc + 1});
        @(negedge clock);
        req = '0;
        repeat (10) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        ptr_m = 0;
        repeat (2) @(negedge clock);
        run_job(4'b0010, 7, 0, 1'b0, 1'b0);

        req = '0;
        repeat (5) @(negedge clock);
        check("expected_events_left", W'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
